// File: rtl/demux_1to8_deser.sv
// Serial-to-parallel 1:8 demultiplexer: steers one bit per slot into 8 lanes and
// presents each completed word on a registered valid/ready output.
module demux_1to8_deser (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       din,
    input  logic       din_valid,
    input  logic       frame_start,
    output logic [7:0] y,
    output logic       y_valid,
    input  logic       y_ready,
    output logic [2:0] slot,
    output logic       overrun,
    input  logic       overrun_clr
);

    logic [2:0] slot_q, slot_d;
    logic [6:0] shadow_q, shadow_d;
    logic [7:0] y_q, y_d;
    logic       y_valid_q, y_valid_d;
    logic       overrun_q, overrun_d;

    logic       word_done;
    logic       xfer;
    logic       load;
    logic       drop;

    always_comb begin
        slot_d    = slot_q;
        shadow_d  = shadow_q;
        y_d       = y_q;
        y_valid_d = y_valid_q;
        overrun_d = overrun_q;

        // frame_start masks completion even when the counter sits on lane 7
        word_done = din_valid && !frame_start && (slot_q == 3'd7);
        xfer      = y_valid_q && y_ready;
        load      = word_done && (!y_valid_q || y_ready);
        drop      = word_done && y_valid_q && !y_ready;

        if (frame_start) begin
            if (din_valid) begin
                shadow_d = {6'b0, din};
                slot_d   = 3'd1;
            end else begin
                shadow_d = 7'b0;
                slot_d   = 3'd0;
            end
        end else if (din_valid) begin
            for (int k = 0; k < 7; k++) begin
                if (slot_q == 3'(k)) begin
                    shadow_d[k] = din;
                end
            end
            slot_d = slot_q + 3'd1;
        end

        if (load) begin
            y_d       = {din, shadow_q};
            y_valid_d = 1'b1;
        end else if (xfer) begin
            y_valid_d = 1'b0;
        end

        if (drop) begin
            overrun_d = 1'b1;
        end else if (overrun_clr) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q    <= 3'd0;
            shadow_q  <= 7'b0;
            y_q       <= 8'h00;
            y_valid_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            slot_q    <= slot_d;
            shadow_q  <= shadow_d;
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign y       = y_q;
    assign y_valid = y_valid_q;
    assign slot    = slot_q;
    assign overrun = overrun_q;

endmodule
